// File: rtl/display_pager.sv
// Snapshots a wide result bus and presents it one PAGE_W-bit page at a time, with manual,
// auto-scroll and button-step page selection plus a freeze control.
module display_pager #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PAGE_W     = 16,
  parameter int unsigned SCROLL_DIV = 125000000,
  localparam int unsigned NUM_PAGES = DATA_W / PAGE_W,
  localparam int unsigned SEL_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              freeze,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              step_next,
  input  logic              step_prev,
  output logic [PAGE_W-1:0] page_out,
  output logic [SEL_W-1:0]  page_idx,
  output logic              page_valid,
  output logic              wrap_pulse
);

  typedef enum logic [1:0] {
    ModeManual = 2'b00,
    ModeAuto   = 2'b01,
    ModeStep   = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  localparam int unsigned CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_PAGES - 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SCROLL_DIV - 1);

  logic [DATA_W-1:0] snapshot_q, snapshot_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              next_last_q, prev_last_q;

  logic              capture;
  logic              rise_next, rise_prev;
  logic              step_fwd, step_back;
  logic [SEL_W-1:0]  idx_inc, idx_dec;
  mode_e             mode_sel;

  assign mode_sel  = mode_e'(mode);
  assign capture   = data_valid & ~freeze;
  assign rise_next = step_next & ~next_last_q;
  assign rise_prev = step_prev & ~prev_last_q;

  assign idx_inc = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  assign idx_dec = (idx_q == '0) ? LastIdx : idx_q - 1'b1;

  always_comb begin
    snapshot_d = snapshot_q;
    valid_d    = valid_q;
    if (capture) begin
      snapshot_d = data_in;
      valid_d    = 1'b1;
    end
  end

  always_comb begin
    cnt_d     = '0;
    idx_d     = idx_q;
    step_fwd  = 1'b0;
    step_back = 1'b0;
    unique case (mode_sel)
      ModeManual: begin
        if (32'(sel) > NUM_PAGES - 1) idx_d = LastIdx;
        else                          idx_d = sel;
      end
      ModeAuto: begin
        if (cnt_q == LastCnt) step_fwd = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      ModeStep: begin
        // Simultaneous presses cancel out.
        step_fwd  = rise_next & ~rise_prev;
        step_back = rise_prev & ~rise_next;
      end
      ModeHold: ;
      default: ;
    endcase
    if (step_fwd)  idx_d = idx_inc;
    if (step_back) idx_d = idx_dec;
    wrap_d = (step_fwd && idx_q == LastIdx) || (step_back && idx_q == '0);
  end

  // Page mux reads the registered index and snapshot, giving one cycle of latency.
  always_comb begin
    page_d = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (idx_q == SEL_W'(i)) page_d = snapshot_q[i*PAGE_W +: PAGE_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot_q  <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      page_q      <= '0;
      // Buttons held through reset release must not register as a press.
      next_last_q <= 1'b1;
      prev_last_q <= 1'b1;
    end else begin
      snapshot_q  <= snapshot_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      page_q      <= page_d;
      next_last_q <= step_next;
      prev_last_q <= step_prev;
    end
  end

  assign page_out   = page_q;
  assign page_idx   = idx_q;
  assign page_valid = valid_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_display_pager.sv
// Bench for display_pager: three configurations (4, 3 and 1 pages) share stimulus and are
// checked every cycle against a page-level behavioural model, plus directed literal checks.
module tb_display_pager;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        data_valid, freeze;
  logic [1:0]  mode, sel;
  logic        step_next, step_prev;

  logic [15:0] po64, po48, po16;
  logic [1:0]  pi64, pi48;
  logic [0:0]  pi16;
  logic        pv64, pv48, pv16, wp64, wp48, wp16;

  always #5 clk = ~clk;

  display_pager #(.DATA_W(64), .PAGE_W(16), .SCROLL_DIV(4)) u_dut64 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .freeze(freeze),
    .mode(mode), .sel(sel), .step_next(step_next), .step_prev(step_prev),
    .page_out(po64), .page_idx(pi64), .page_valid(pv64), .wrap_pulse(wp64)
  );

  display_pager #(.DATA_W(48), .PAGE_W(16), .SCROLL_DIV(3)) u_dut48 (
    .clk(clk), .rst(rst), .data_in(data_in[47:0]), .data_valid(data_valid), .freeze(freeze),
    .mode(mode), .sel(sel), .step_next(step_next), .step_prev(step_prev),
    .page_out(po48), .page_idx(pi48), .page_valid(pv48), .wrap_pulse(wp48)
  );

  display_pager #(.DATA_W(16), .PAGE_W(16), .SCROLL_DIV(2)) u_dut16 (
    .clk(clk), .rst(rst), .data_in(data_in[15:0]), .data_valid(data_valid), .freeze(freeze),
    .mode(mode), .sel(sel[0]), .step_next(step_next), .step_prev(step_prev),
    .page_out(po16), .page_idx(pi16), .page_valid(pv16), .wrap_pulse(wp16)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d at %0t: got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Page-level reference model: index as a plain integer with modular wrap.
  int          np  [3] = '{4, 3, 1};
  int          div [3] = '{4, 3, 2};
  int          dw  [3] = '{64, 48, 16};
  logic [63:0] m_snap [3];
  int          m_idx  [3];
  int          m_cnt  [3];
  bit          m_pv [3], m_wp [3], m_pn [3], m_pp [3];
  logic [15:0] m_po [3];
  int          s_m, ni_m, delta_m;
  bit          rn_m, rp_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_snap[k] = '0; m_idx[k] = 0; m_cnt[k] = 0; m_pv[k] = 0; m_wp[k] = 0;
        m_po[k] = '0; m_pn[k] = 1; m_pp[k] = 1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_po[k] = 16'(m_snap[k] >> (16 * m_idx[k]));
        rn_m = step_next && !m_pn[k];
        rp_m = step_prev && !m_pp[k];
        m_pn[k] = step_next;
        m_pp[k] = step_prev;
        if (data_valid && !freeze) begin
          m_snap[k] = data_in & mask(dw[k]);
          m_pv[k] = 1;
        end
        ni_m = m_idx[k];
        delta_m = 0;
        case (mode)
          2'd0: begin
            s_m = (k == 2) ? int'(sel[0]) : int'(sel);
            ni_m = (s_m > np[k] - 1) ? np[k] - 1 : s_m;
            m_cnt[k] = 0;
          end
          2'd1: begin
            if (m_cnt[k] == div[k] - 1) begin
              m_cnt[k] = 0;
              delta_m = 1;
            end else m_cnt[k]++;
          end
          2'd2: begin
            m_cnt[k] = 0;
            if (rn_m && !rp_m) delta_m = 1;
            else if (rp_m && !rn_m) delta_m = -1;
          end
          default: m_cnt[k] = 0;
        endcase
        m_wp[k] = 0;
        if (delta_m != 0) begin
          ni_m = m_idx[k] + delta_m;
          if (ni_m >= np[k]) begin ni_m = 0; m_wp[k] = 1; end
          else if (ni_m < 0) begin ni_m = np[k] - 1; m_wp[k] = 1; end
        end
        m_idx[k] = ni_m;
      end
    end
  end

  logic [15:0] a_po [3];
  logic [1:0]  a_pi [3];
  logic        a_pv [3], a_wp [3];
  assign a_po[0] = po64; assign a_po[1] = po48; assign a_po[2] = po16;
  assign a_pi[0] = pi64; assign a_pi[1] = pi48; assign a_pi[2] = {1'b0, pi16};
  assign a_pv[0] = pv64; assign a_pv[1] = pv48; assign a_pv[2] = pv16;
  assign a_wp[0] = wp64; assign a_wp[1] = wp48; assign a_wp[2] = wp16;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("model_page_out", k, 64'(a_po[k]), 64'(m_po[k]));
        check("model_page_idx", k, 64'(a_pi[k]), 64'(m_idx[k]));
        check("model_page_valid", k, 64'(a_pv[k]), 64'(m_pv[k]));
        check("model_wrap_pulse", k, 64'(a_wp[k]), 64'(m_wp[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] pg [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

  initial begin
    rst = 0; data_in = '0; data_valid = 0; freeze = 0; mode = 2'd2; sel = 0;
    step_next = 1; step_prev = 0;
    tick(3);
    chk_en = 1;
    check("reset_page_out", 0, 64'(po64), 64'h0);
    check("reset_page_valid", 0, 64'(pv64), 64'h0);
    rst = 1;
    tick(3);
    check("held_btn_no_step", 0, 64'(pi64), 64'h0);

    step_next = 0; mode = 2'd0; data_in = 64'h0123456789ABCDEF; data_valid = 1;
    tick(1); data_valid = 0; tick(2);
    check("capture_valid", 0, 64'(pv64), 64'h1);
    check("capture_page0", 0, 64'(po64), 64'hCDEF);
    sel = 3; tick(2);
    check("manual_sel3", 0, 64'(po64), 64'h0123);
    check("clamp48_idx", 1, 64'(pi48), 64'h2);
    check("clamp48_page", 1, 64'(po48), 64'h4567);
    check("clamp16_idx", 2, 64'(pi16), 64'h0);

    freeze = 1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; data_valid = 1;
    tick(1); data_valid = 0; tick(2);
    check("freeze_hold", 0, 64'(po64), 64'h0123);
    freeze = 0; data_valid = 1; tick(1); data_valid = 0; tick(2);
    check("unfreeze_capture", 0, 64'(po64), 64'hFFFF);

    data_in = 64'h0123456789ABCDEF; data_valid = 1; sel = 0;
    tick(1); data_valid = 0; tick(2);
    mode = 2'd1;
    for (int j = 1; j <= 4; j++) begin
      tick(4);
      check("auto_idx", 0, 64'(pi64), 64'(j % 4));
      check("auto_wrap", 0, 64'(wp64), 64'(j == 4));
      check("auto_lag", 0, 64'(po64), 64'(pg[(j - 1) % 4]));
    end
    tick(1);
    check("auto_wrap_one_cycle", 0, 64'(wp64), 64'h0);

    mode = 2'd0; sel = 0; tick(2);
    mode = 2'd2; step_prev = 1; tick(1);
    check("step_prev_wrap_idx", 0, 64'(pi64), 64'h3);
    check("step_prev_wrap_pulse", 0, 64'(wp64), 64'h1);
    step_prev = 0; step_next = 1; tick(10);
    check("step_held_once", 0, 64'(pi64), 64'h0);
    step_next = 0; tick(1); step_next = 1; tick(1); step_next = 0; tick(1);
    check("step_next_idx", 0, 64'(pi64), 64'h1);
    step_next = 1; step_prev = 1; tick(1);
    check("step_both_idx", 0, 64'(pi64), 64'h1);
    check("step_both_wrap", 0, 64'(wp64), 64'h0);
    step_next = 0; step_prev = 0; tick(1);

    mode = 2'd0; sel = 2; tick(2);
    mode = 2'd1; tick(2);
    check("pre_reset_idx", 0, 64'(pi64), 64'h2);
    step_next = 1;
    #2 rst = 0;
    #1;
    check("async_rst_page_out", 0, 64'(po64), 64'h0);
    check("async_rst_page_idx", 0, 64'(pi64), 64'h0);
    check("async_rst_valid", 0, 64'(pv64), 64'h0);
    check("async_rst_wrap", 0, 64'(wp64), 64'h0);
    tick(2);
    rst = 1; mode = 2'd2; tick(3);
    check("btn_through_reset", 0, 64'(pi64), 64'h0);
    step_next = 0; tick(1);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 499) != 0);
      data_in = {$urandom, $urandom};
      data_valid = ($urandom_range(0, 3) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step_next = ~step_next;
      if ($urandom_range(0, 3) == 0) step_prev = ~step_prev;
    end
    tick(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
